// File: rtl/stepper_ramp_controller_pkg.sv
// Shared types and the coil phase table for the ramped stepper drivers.
// Every block that needs drive modes, coil codes or the FSM states imports this package.
package stepper_pkg;

    typedef enum logic [1:0] {
        FULL = 2'd0,
        WAVE = 2'd1,
        HALF = 2'd2
    } drive_mode_e;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        NEG   = 2'b01,
        POS   = 2'b10
    } coil_e;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_e;

    // Encoding 3 is not a drive mode and falls back to full-step.
    function automatic drive_mode_e mode_from_cmd(input logic [1:0] cmd_mode);
        drive_mode_e m;
        case (cmd_mode)
            2'd1:    m = WAVE;
            2'd2:    m = HALF;
            default: m = FULL;
        endcase
        return m;
    endfunction

    // Returns {coil_a, coil_b}; brake (2'b11) is never produced.
    function automatic logic [3:0] phase_decode(input drive_mode_e mode, input logic [2:0] pos);
        coil_e a;
        coil_e b;
        a = COAST;
        b = COAST;
        case (mode)
            WAVE: begin
                case (pos[1:0])
                    2'd0:    begin a = POS;   b = COAST; end
                    2'd1:    begin a = COAST; b = POS;   end
                    2'd2:    begin a = NEG;   b = COAST; end
                    2'd3:    begin a = COAST; b = NEG;   end
                    default: begin a = COAST; b = COAST; end
                endcase
            end
            HALF: begin
                case (pos)
                    3'd0:    begin a = POS;   b = POS;   end
                    3'd1:    begin a = COAST; b = POS;   end
                    3'd2:    begin a = NEG;   b = POS;   end
                    3'd3:    begin a = NEG;   b = COAST; end
                    3'd4:    begin a = NEG;   b = NEG;   end
                    3'd5:    begin a = COAST; b = NEG;   end
                    3'd6:    begin a = POS;   b = NEG;   end
                    3'd7:    begin a = POS;   b = COAST; end
                    default: begin a = COAST; b = COAST; end
                endcase
            end
            default: begin
                case (pos[1:0])
                    2'd0:    begin a = POS; b = POS; end
                    2'd1:    begin a = NEG; b = POS; end
                    2'd2:    begin a = NEG; b = NEG; end
                    2'd3:    begin a = POS; b = NEG; end
                    default: begin a = COAST; b = COAST; end
                endcase
            end
        endcase
        return {a, b};
    endfunction

endpackage

// File: rtl/stepper_ramp_controller_if.sv
// Move-command handshake between the register block (master) and a stepper channel (slave).
interface stepper_ramp_controller_if #(
    parameter int POS_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [POS_WIDTH-1:0] cmd_target;
    logic [1:0]           cmd_mode;

    modport master (output cmd_valid, output cmd_target, output cmd_mode, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_target, input cmd_mode, output cmd_ready);
endinterface

// File: rtl/stepper_ramp_controller_us_tick_gen.sv
// Free-running microsecond strobe: us_tick is high for one clk each time the divider wraps.
module us_tick_gen #(
    parameter int CLK_PER_US = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic us_tick
);
    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Divider next state; the strobe is registered so it lines up with the wrap cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Divider and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign us_tick = tick_q;
endmodule

// File: rtl/stepper_ramp_controller.sv
// One stepper channel: absolute-position moves with a table-driven symmetric accel/decel ramp,
// soft-stop, enable/coast and a done pulse, driving one TB6612-style dual H-bridge.
module stepper_ramp_controller
    import stepper_pkg::*;
#(
    parameter int POS_WIDTH   = 16,
    parameter int TIMER_WIDTH = 32,
    parameter int MAP_NUM     = 100,
    parameter int CLK_PER_US  = 27
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    stepper_ramp_controller_if.slave       cmd,
    input  logic                           stop_req,
    input  logic [MAP_NUM*TIMER_WIDTH-1:0] period_map,
    output logic [1:0]                     coil_a,
    output logic [1:0]                     coil_b,
    output logic                           standby_n,
    output logic [POS_WIDTH-1:0]           position,
    output logic                           busy,
    output logic                           done
);
    localparam int IDX_W = (MAP_NUM > 1) ? $clog2(MAP_NUM) : 1;
    localparam logic [POS_WIDTH-1:0] IDX_CAP = POS_WIDTH'(MAP_NUM - 1);

    state_e                 state_q, state_d;
    logic [POS_WIDTH-1:0]   pos_q, pos_d;
    logic [POS_WIDTH-1:0]   target_q, target_d;
    logic [POS_WIDTH-1:0]   start_q, start_d;
    drive_mode_e            mode_q, mode_d;
    logic [TIMER_WIDTH-1:0] ivl_q, ivl_d;
    logic                   done_q, done_d;
    logic [3:0]             coil_q, coil_d;

    logic                   us_tick_s;
    logic                   cmd_ready_s;
    logic                   fwd_s;
    logic [POS_WIDTH-1:0]   dist_start_s;
    logic [POS_WIDTH-1:0]   dist_tgt_s;
    logic [POS_WIDTH-1:0]   dist_min_s;
    logic [POS_WIDTH-1:0]   ramp_dist_s;
    logic [IDX_W-1:0]       ramp_idx_s;
    logic [TIMER_WIDTH-1:0] period_raw_s;
    logic [TIMER_WIDTH-1:0] period_s;
    logic                   step_due_s;
    logic                   stop_hold_s;

    us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .us_tick (us_tick_s)
    );

    // Ramp index = distance to the nearer end of the move, capped at the last table entry.
    always_comb begin
        if (pos_q >= start_q) begin
            dist_start_s = pos_q - start_q;
        end else begin
            dist_start_s = start_q - pos_q;
        end
        if (target_q >= pos_q) begin
            dist_tgt_s = target_q - pos_q;
        end else begin
            dist_tgt_s = pos_q - target_q;
        end
        if (dist_start_s < dist_tgt_s) begin
            dist_min_s = dist_start_s;
        end else begin
            dist_min_s = dist_tgt_s;
        end
        if (dist_min_s > IDX_CAP) begin
            ramp_dist_s = IDX_CAP;
        end else begin
            ramp_dist_s = dist_min_s;
        end
        fwd_s        = (target_q > pos_q);
        ramp_idx_s   = ramp_dist_s[IDX_W-1:0];
        period_raw_s = period_map[int'(ramp_idx_s) * TIMER_WIDTH +: TIMER_WIDTH];
        if (period_raw_s == '0) begin
            period_s = TIMER_WIDTH'(1);
        end else begin
            period_s = period_raw_s;
        end
        step_due_s  = (ivl_q >= (period_s - TIMER_WIDTH'(1)));
        // A stop requested at the very first position leaves nothing to decelerate over.
        stop_hold_s = stop_req && (ramp_dist_s == '0);
    end

    // Move FSM: accept, step timing, soft-stop retargeting and arrival.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        target_d    = target_q;
        start_d     = start_q;
        mode_d      = mode_q;
        ivl_d       = ivl_q;
        done_d      = 1'b0;
        cmd_ready_s = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_s = 1'b1;
                    if (cmd.cmd_valid) begin
                        target_d = cmd.cmd_target;
                        start_d  = pos_q;
                        mode_d   = mode_from_cmd(cmd.cmd_mode);
                        ivl_d    = '0;
                        state_d  = MOVE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                MOVE: begin
                    if (pos_q == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (stop_req) begin
                            target_d = fwd_s ? (pos_q + ramp_dist_s) : (pos_q - ramp_dist_s);
                        end else begin
                            target_d = target_q;
                        end
                        if (!us_tick_s || stop_hold_s) begin
                            ivl_d = ivl_q;
                        end else if (step_due_s) begin
                            ivl_d = '0;
                            pos_d = fwd_s ? (pos_q + POS_WIDTH'(1)) : (pos_q - POS_WIDTH'(1));
                        end else begin
                            ivl_d = ivl_q + TIMER_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (enable) begin
            coil_d = phase_decode(mode_q, pos_q[2:0]);
        end else begin
            coil_d = {COAST, COAST};
        end
    end

    // State, datapath and registered coil outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            target_q <= '0;
            start_q  <= '0;
            mode_q   <= FULL;
            ivl_q    <= '0;
            done_q   <= 1'b0;
            coil_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            start_q  <= start_d;
            mode_q   <= mode_d;
            ivl_q    <= ivl_d;
            done_q   <= done_d;
            coil_q   <= coil_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_s;
    assign coil_a        = coil_q[3:2];
    assign coil_b        = coil_q[1:0];
    assign standby_n     = enable;
    assign position      = pos_q;
    assign busy          = (state_q == MOVE);
    assign done          = done_q;
endmodule
